// File: rtl/write_fsm_if.sv
// ============================================================================
// Module   : write_fsm_if
// Brief    : ALU result stream and register-file write port of write_fsm.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface write_fsm_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              isreg;
    logic [ADDR_W-1:0] regsel;
    logic              res_valid;
    logic [WIDTH-1:0]  res_data;
    logic              res_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              busy;
    logic              done;

    modport master (
        output isreg, regsel, res_valid, res_data,
        input  res_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  isreg, regsel, res_valid, res_data,
        output res_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/write_fsm.sv
// ============================================================================
// Module   : write_fsm
// Brief    : Write-back sequencer: burst of ELEMS results to consecutive regs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module write_fsm #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int ELEMS  = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    write_fsm_if.slave   bus
);
    localparam int CNT_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;
    logic              w_start;
    logic              w_accept;
    logic              w_ready;
    logic              w_busy;
    logic              w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_accept = 1'b0;
        w_ready  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.isreg) begin
                    w_start = 1'b1;
                    w_next  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                w_ready  = 1'b1;
                w_busy   = 1'b1;
                w_accept = bus.res_valid;
                if (bus.res_valid && (r_cnt == CNT_W'(ELEMS - 1))) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Address arithmetic truncates to ADDR_W bits so the burst wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_base    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_start) begin
                r_base <= bus.regsel;
                r_cnt  <= '0;
            end
            if (w_accept) begin
                r_cnt     <= r_cnt + 1'b1;
                r_wr_addr <= r_base + ADDR_W'(r_cnt);
                r_wr_data <= bus.res_data;
            end
        end
    end

    assign bus.res_ready = w_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
endmodule

`default_nettype wire
